// File: rtl/iccm_boot_loader.sv
// ICCM boot loader.
// Receives a framed byte stream from the programming UART:
//   0xA5 | LEN_LO | LEN_HI | LEN*4 payload bytes | CSUM
// The payload is packed into little-endian 32-bit words, and each word is
// written to the ICCM with a one-cycle write strobe. The core is held in
// program reset from the start of a load until a frame passes its checksum.
//
// Bus handshake: rx_dv_i is a one-cycle valid strobe and has no ready.
// Every strobe is consumed in the cycle it arrives. we_o is a one-cycle
// valid strobe to the ICCM, and the ICCM always accepts it.
module iccm_boot_loader #(
    parameter int AW          = 12,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          prog_i,
    input  logic          rx_dv_i,
    input  logic [7:0]    rx_byte_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   wdata_o,
    output logic          reset_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]  SYNC_B   = 8'hA5;
    localparam logic [16:0] MAX_LEN  = 17'(1 << AW);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
    } state_t;

    state_t          state_q;
    logic            prog_q;
    logic [AW:0]     idx_q;       // one extra bit so LEN = 2**AW cannot alias word 0
    logic [1:0]      byte_cnt_q;
    logic [15:0]     len_q;
    logic [7:0]      csum_q;
    logic [TW-1:0]   timer_q;
    logic [23:0]     lanes_q;     // lanes 0..2 of the word being assembled
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            reset_q;
    logic            done_q;
    logic            err_q;

    logic            prog_rise;
    logic [15:0]     len_d;
    logic            len_too_big;
    logic            last_word;

    // A restart is taken on the first cycle that prog_i is high after being low.
    assign prog_rise   = prog_i & ~prog_q;
    // Full length as it becomes known on the LEN_HI byte.
    assign len_d       = {rx_byte_i, len_q[7:0]};
    assign len_too_big = {1'b0, len_d} > MAX_LEN;
    // The word now completing is word LEN-1.
    assign last_word   = ({{(16 - AW){1'b0}}, idx_q} + 17'd1) == {1'b0, len_q};

    // Frame parser FSM with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            prog_q     <= 1'b0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            timer_q    <= '0;
            lanes_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            reset_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prog_q <= prog_i;
            we_q   <= 1'b0;
            if (prog_rise) begin
                // A restart wins over any byte that arrives in the same cycle.
                state_q    <= SYNC;
                reset_q    <= 1'b0;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                idx_q      <= '0;
                byte_cnt_q <= '0;
                csum_q     <= '0;
                timer_q    <= '0;
            end else begin
                case (state_q)
                    SYNC: begin
                        if (rx_dv_i && rx_byte_i == SYNC_B) begin
                            state_q <= LEN_LO;
                        end
                    end
                    LEN_LO, LEN_HI, DATA, CSUM: begin
                        if (rx_dv_i) begin
                            // A byte that arrives together with expiry is accepted.
                            timer_q <= '0;
                            case (state_q)
                                LEN_LO: begin
                                    len_q[7:0] <= rx_byte_i;
                                    state_q    <= LEN_HI;
                                end
                                LEN_HI: begin
                                    len_q[15:8] <= rx_byte_i;
                                    if (len_too_big) begin
                                        state_q <= ERR;
                                        err_q   <= 1'b1;
                                    end else if (len_d == 16'd0) begin
                                        state_q <= CSUM;
                                    end else begin
                                        state_q <= DATA;
                                    end
                                end
                                DATA: begin
                                    csum_q     <= csum_q + rx_byte_i;
                                    byte_cnt_q <= byte_cnt_q + 2'd1;
                                    if (byte_cnt_q != 2'd3) begin
                                        lanes_q[8*byte_cnt_q +: 8] <= rx_byte_i;
                                    end else begin
                                        we_q    <= 1'b1;
                                        addr_q  <= idx_q[AW-1:0];
                                        wdata_q <= {rx_byte_i, lanes_q};
                                        idx_q   <= idx_q + 1'b1;
                                        if (last_word) begin
                                            state_q <= CSUM;
                                        end
                                    end
                                end
                                default: begin  // CSUM
                                    if (rx_byte_i == csum_q) begin
                                        state_q <= DONE;
                                        done_q  <= 1'b1;
                                        reset_q <= 1'b1;
                                    end else begin
                                        state_q <= ERR;
                                        err_q   <= 1'b1;
                                    end
                                end
                            endcase
                        end else if (timer_q == TIMER_LAST) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    default: begin
                        // In IDLE, DONE and ERR, bytes are ignored until the next prog_i edge.
                    end
                endcase
            end
        end
    end

    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign reset_o = reset_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Bench for iccm_boot_loader.
// A frame-level model predicts the ICCM writes and the final status.
// A monitor compares every we_o pulse against the expected-write queue.
module tb_iccm_boot_loader;

  localparam int AW = 4;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic          reset_o;
  logic          done_o;
  logic          err_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW+31:0] exp_q[$];
  logic [7:0]     frame_q[$];
  logic           exp_done, exp_err, exp_rst;

  iccm_boot_loader #(.AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst), .prog_i(prog), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
    .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .reset_o(reset_o), .done_o(done_o), .err_o(err_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rst === 1'b0 && we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h expected no write", addr_o, wdata_o);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(addr_o), 32'(e[AW+31:32]));
        check("write_data", wdata_o, e[31:0]);
      end
    end
  end

  // Frame-level model: parses frame_q, pushes expected writes and sets the status
  // the loader should show after the bytes have been sent following a restart.
  task automatic model_frame();
    int i, len, sum;
    logic [31:0] word;
    logic [AW-1:0] a;
    exp_done = 1'b0; exp_err = 1'b0; exp_rst = 1'b0;  // still waiting
    i = 0;
    while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
    if (i >= frame_q.size()) return;
    i++;
    if (i + 1 >= frame_q.size()) return;
    len = int'(frame_q[i]) + 256 * int'(frame_q[i+1]);
    i += 2;
    if (len > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    sum = 0;
    for (int w = 0; w < len; w++) begin
      if (i + 4 > frame_q.size()) return;
      word = {frame_q[i+3], frame_q[i+2], frame_q[i+1], frame_q[i]};
      sum += int'(frame_q[i]) + int'(frame_q[i+1]) + int'(frame_q[i+2]) + int'(frame_q[i+3]);
      a = AW'(w);
      exp_q.push_back({a, word});
      i += 4;
    end
    if (i >= frame_q.size()) return;
    if (frame_q[i] == 8'(sum % 256)) begin
      exp_done = 1'b1;
      exp_rst  = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int gap;
    rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
    rx_byte = 8'($urandom);
    gap = $urandom_range(0, 3);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic start_load();
    prog = 1'b0;
    @(posedge clk); #1;
    prog = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame();
    foreach (frame_q[k]) send_byte(frame_q[k]);
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_done_o"}, 32'(done_o), 32'(exp_done));
    check({tag, "_err_o"}, 32'(err_o), 32'(exp_err));
    check({tag, "_reset_o"}, 32'(reset_o), 32'(exp_rst));
  endtask

  task automatic finish_frame(input string tag);
    repeat (3) @(posedge clk);
    check_status(tag);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  // Build a frame: garbage bytes, sync, length, random payload, checksum (optionally corrupted).
  task automatic build(input int len, input bit bad, input int garbage);
    int sum;
    logic [7:0] b;
    frame_q.delete();
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      frame_q.push_back(b);
    end
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(len));
    frame_q.push_back(8'(len >> 8));
    sum = 0;
    for (int k = 0; k < 4 * len; k++) begin
      b = 8'($urandom);
      sum += int'(b);
      frame_q.push_back(b);
    end
    b = 8'(sum % 256);
    frame_q.push_back(bad ? b + 8'd1 : b);
  endtask

  task automatic load_directed(input logic [7:0] csum);
    logic [7:0] fixed [12];
    fixed = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    fixed[11] = csum;
    frame_q.delete();
    foreach (fixed[k]) frame_q.push_back(fixed[k]);
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_we_o"}, 32'(we_o), 32'd0);
    check({tag, "_addr_o"}, 32'(addr_o), 32'd0);
    check({tag, "_wdata_o"}, wdata_o, 32'd0);
    check({tag, "_reset_o"}, 32'(reset_o), 32'd1);
    check({tag, "_done_o"}, 32'(done_o), 32'd0);
    check({tag, "_err_o"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; prog = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Bytes before any prog_i edge are ignored.
    load_directed(8'h64);
    send_frame();
    exp_done = 1'b0; exp_err = 1'b0; exp_rst = 1'b1;
    finish_frame("idle_ignore");

    // Directed two-word frame; the checksum is the payload sum mod 256 = 0x64.
    start_load();
    load_directed(8'h64);
    model_frame();
    send_frame();
    finish_frame("two_word_ok");

    // Same frame with a wrong checksum.
    start_load();
    load_directed(8'h55);
    model_frame();
    send_frame();
    finish_frame("two_word_bad");

    // Zero-length frame.
    start_load();
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model_frame();
    send_frame();
    finish_frame("len_zero");

    // Length 2**AW + 1 is rejected right after LEN_HI.
    start_load();
    frame_q = '{8'hA5, 8'(17), 8'h00};
    model_frame();
    send_frame();
    finish_frame("len_too_big");

    // Maximum length 2**AW loads every address.
    start_load();
    build(1 << AW, 1'b0, 0);
    model_frame();
    send_frame();
    finish_frame("len_max");

    // Leading garbage before the sync byte.
    start_load();
    build(2, 1'b0, 0);
    frame_q.push_front(8'hFF);
    frame_q.push_front(8'h00);
    model_frame();
    send_frame();
    finish_frame("garbage");

    // Timeout after 2 payload bytes.
    start_load();
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    model_frame();
    send_frame();
    repeat (30) @(posedge clk);
    check_status("pre_timeout");
    repeat (12) @(posedge clk);
    exp_err = 1'b1;
    finish_frame("timeout");

    // A restart during DATA after 6 payload bytes: only word 0 is written.
    start_load();
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    model_frame();
    send_frame();
    start_load();
    check_status("restart_flags");
    check("restart_pending_writes", 32'(exp_q.size()), 32'd0);
    #1;
    build(3, 1'b0, 0);
    model_frame();
    send_frame();
    finish_frame("after_restart");

    // An asynchronous reset during DATA; afterwards bytes are ignored until a prog_i edge.
    start_load();
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    model_frame();
    send_frame();
    rst = 1'b1; prog = 1'b0;
    check_reset_values("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_reset_pending_writes", 32'(exp_q.size()), 32'd0);
    load_directed(8'h64);
    send_frame();
    exp_done = 1'b0; exp_err = 1'b0; exp_rst = 1'b1;
    finish_frame("post_reset_ignore");

    // A restart edge together with an 0xA5 strobe drops that byte, so the frame never syncs.
    prog = 1'b0;
    @(posedge clk); #1;
    prog = 1'b1; rx_dv = 1'b1; rx_byte = 8'hA5;
    @(posedge clk); #1;
    rx_dv = 1'b0;
    frame_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    model_frame();
    send_frame();
    finish_frame("restart_vs_byte");

    // Random frames.
    for (int r = 0; r < 10; r++) begin
      start_load();
      build($urandom_range(0, 1 << AW), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      model_frame();
      send_frame();
      finish_frame("random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
